ram_controller: RTL

- Memory stage directly downstream of the memory address register (MAR); consumes the latched address MA and services one byte/halfword/word access to an internal byte-addressable, big-endian RAM.
- Uses the datapath's MOV/MFC handshake: the control unit raises MOV, and the block answers with MFC after a fixed wait-state count.
- MAR updates on the falling edge of Clock; this block samples on the rising edge, so MA is stable half a cycle before capture.

---
 rtl/ram_ctrl_pkg.sv | 8 +
 rtl/ram_controller_if.sv | 14 +
 rtl/ram_byte_array.sv | 16 +
 rtl/ram_controller.sv | 88 ++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared type codes, FSM state encoding and wait-counter width for ram_controller
package ram_ctrl_pkg;
  localparam int CNT_W = 4;
  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/ram_controller_if.sv
// ram_controller_if: MOV/MFC memory bus (MA, DataIn, MOV, RW, Type, Signed -> DataOut, MFC, Align_Err)
interface ram_controller_if;
  logic [31:0] MA;
  logic [31:0] DataIn;
  logic        MOV;
  logic        RW;
  logic [1:0]  Type;
  logic        Signed;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Align_Err;
  modport master (output MA, DataIn, MOV, RW, Type, Signed, input DataOut, MFC, Align_Err);
  modport slave (input MA, DataIn, MOV, RW, Type, Signed, output DataOut, MFC, Align_Err);
endinterface

// File: rtl/ram_byte_array.sv
// ram_byte_array: 2^ADDR_W x 8 storage; clk, addr, we[i] writes mem[addr+i] from wdata lane i (lane 0 = [31:24]), rdata = big-endian 4 bytes from addr
module ram_byte_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [7:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
  assign rdata = {mem[addr], mem[addr + ADDR_W'(1)], mem[addr + ADDR_W'(2)], mem[addr + ADDR_W'(3)]};
endmodule

// File: rtl/ram_controller.sv
// ram_controller: MOV/MFC memory stage; Clock, Reset_n (sync active-low), bus (slave modport) servicing byte/half/word big-endian RAM accesses
module ram_controller
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clock,
  input  logic Reset_n,
  ram_controller_if.slave bus
);
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  a;
  logic               rw_q, sgn_q;
  logic [1:0]         type_q;
  logic [31:0]        din_q, dout, dout_n, rdata, wdata, ext;
  logic               mfc, mfc_n, aerr, aerr_n, mis, access;
  logic [3:0]         we;
  logic               unused_ma;
  assign unused_ma = ^bus.MA[31:ADDR_W];
  // reserved type 11 falls into the word case everywhere
  assign mis = bus.Type == TYPE_BYTE ? 1'b0 :
               bus.Type == TYPE_HALF ? bus.MA[0] : |bus.MA[1:0];
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      mfc   <= 1'b0;
      aerr  <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mfc   <= mfc_n;
      aerr  <= aerr_n;
      dout  <= dout_n;
      if (state == IDLE && bus.MOV) begin
        a      <= bus.MA[ADDR_W-1:0];
        rw_q   <= bus.RW;
        type_q <= bus.Type;
        sgn_q  <= bus.Signed;
        din_q  <= bus.DataIn;
      end
    end
  end
  always_comb
    state_n = state == IDLE ? (bus.MOV ? (mis ? DONE : WAIT) : IDLE) :
              state == WAIT ? (cnt == '0 ? DONE : WAIT) :
              state == DONE ? (bus.MOV ? DONE : IDLE) : IDLE;
  assign access = state == WAIT && cnt == '0;
  assign ext = type_q == TYPE_BYTE ? {{24{sgn_q & rdata[31]}}, rdata[31:24]} :
               type_q == TYPE_HALF ? {{16{sgn_q & rdata[31]}}, rdata[31:16]} : rdata;
  assign wdata = type_q == TYPE_BYTE ? {din_q[7:0], 24'h0} :
                 type_q == TYPE_HALF ? {din_q[15:0], 16'h0} : din_q;
  always_comb begin
    cnt_n  = cnt;
    mfc_n  = 1'b0;
    aerr_n = 1'b0;
    dout_n = dout;
    if (state == IDLE) begin
      cnt_n  = bus.MOV ? CNT_W'(WAIT_CYCLES) : cnt;
      mfc_n  = bus.MOV & mis;
      aerr_n = bus.MOV & mis;
    end else if (state == WAIT) begin
      cnt_n  = access ? cnt : cnt - 1'b1;
      mfc_n  = access;
      dout_n = access && rw_q ? ext : dout;
    end else if (state == DONE) begin
      mfc_n  = bus.MOV;
      aerr_n = bus.MOV & aerr;
    end
  end
  // the memory has no reset, so a reset landing on the access edge must veto the write
  assign we = !(access && !rw_q && Reset_n) ? 4'b0000 :
              type_q == TYPE_BYTE ? 4'b0001 :
              type_q == TYPE_HALF ? 4'b0011 : 4'b1111;
  ram_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk  (Clock),
    .addr (a),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata)
  );
  assign bus.DataOut   = dout;
  assign bus.MFC       = mfc;
  assign bus.Align_Err = aerr;
endmodule
